// File: rtl/cacheline_arbiter_rr_if.sv
// Cacheline arbiter bus: client-side request/return signals plus the
// adaptor-side strobe/response signals, bundled for the arbiter port.
//
// Handshake: a client raises cli_read or cli_write (level) together with
// its address/wdata slice and holds it until its cli_resp bit pulses for one
// cycle; cli_rdata is valid in that same cycle. Toward the adaptor,
// mmem_read/mmem_write stay high with mmem_address/mmem_wdata stable until
// the cycle in which mmem_resp is seen; mmem_rdata is valid with mmem_resp.
interface cacheline_arbiter_rr_if #(
    parameter int N_CLIENTS = 2,
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32
);
    logic [N_CLIENTS-1:0]        cli_read;
    logic [N_CLIENTS-1:0]        cli_write;
    logic [N_CLIENTS*ADDR_W-1:0] cli_address;
    logic [N_CLIENTS*LINE_W-1:0] cli_wdata;
    logic [LINE_W-1:0]           cli_rdata;
    logic [N_CLIENTS-1:0]        cli_resp;

    logic                        mmem_read;
    logic                        mmem_write;
    logic [ADDR_W-1:0]           mmem_address;
    logic [LINE_W-1:0]           mmem_wdata;
    logic [LINE_W-1:0]           mmem_rdata;
    logic                        mmem_resp;

    // Arbiter side
    modport slave (
        input  cli_read, cli_write, cli_address, cli_wdata,
        input  mmem_rdata, mmem_resp,
        output cli_rdata, cli_resp,
        output mmem_read, mmem_write, mmem_address, mmem_wdata
    );

    // Environment side (caches + adaptor)
    modport master (
        output cli_read, cli_write, cli_address, cli_wdata,
        output mmem_rdata, mmem_resp,
        input  cli_rdata, cli_resp,
        input  mmem_read, mmem_write, mmem_address, mmem_wdata
    );
endinterface

// File: rtl/cacheline_arbiter_rr.sv
// N-client round-robin cacheline arbiter between private L1 caches and the
// single cacheline adaptor. One transaction in flight at a time:
// IDLE -> ISSUE -> DONE -> IDLE. All outputs are registered.
// Optional feature macro: ARB_PERF_CNT_EN (per-client saturating grant
// counters on perf_grant_cnt; tied to 0 when undefined).
module cacheline_arbiter_rr #(
    parameter int N_CLIENTS = 2,
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    cacheline_arbiter_rr_if.slave   bus,
    output logic [N_CLIENTS*32-1:0] perf_grant_cnt,
    output logic [1:0]              state_dbg
);

    // A single client still needs a 1-bit grant index.
    localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(N_CLIENTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant_q;
    logic                 op_write_q;
    logic                 mmem_read_q;
    logic                 mmem_write_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [LINE_W-1:0]    wdata_q;
    logic [LINE_W-1:0]    rdata_q;
    logic [N_CLIENTS-1:0] resp_q;

    logic [N_CLIENTS-1:0] req;
    logic                 grant_valid;
    logic [IDX_W-1:0]     grant_idx;
    logic [ADDR_W-1:0]    sel_addr;
    logic [LINE_W-1:0]    sel_wdata;
    logic                 sel_write;
    logic [N_CLIENTS-1:0] grant_onehot;

    assign req = bus.cli_read | bus.cli_write;

    // Round-robin search: first requester after rr_ptr, wrapping modulo N_CLIENTS.
    always_comb begin
        int cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N_CLIENTS; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_CLIENTS) cand = cand - N_CLIENTS;
            for (int i = 0; i < N_CLIENTS; i++) begin
                if (!grant_valid && (i == cand) && req[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = IDX_W'(i);
                end
            end
        end
    end

    // Mux the winning client's address, write line and op; write beats read.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (IDX_W'(i) == grant_idx) begin
                sel_addr  = bus.cli_address[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.cli_wdata[i*LINE_W +: LINE_W];
                sel_write = bus.cli_write[i];
            end
        end
    end

    // One-hot form of the registered grant, used for the completion pulse.
    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (IDX_W'(i) == grant_q) grant_onehot[i] = 1'b1;
        end
    end

    // Arbitration FSM with registered strobes, return data and response pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            rr_ptr       <= RR_RESET;
            grant_q      <= '0;
            op_write_q   <= 1'b0;
            mmem_read_q  <= 1'b0;
            mmem_write_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    resp_q <= '0;
                    if (grant_valid) begin
                        grant_q      <= grant_idx;
                        op_write_q   <= sel_write;
                        addr_q       <= sel_addr;
                        wdata_q      <= sel_wdata;
                        mmem_read_q  <= ~sel_write;
                        mmem_write_q <= sel_write;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Address/wdata come from registers, so client-side
                    // changes during the transfer cannot disturb it.
                    if (bus.mmem_resp) begin
                        mmem_read_q  <= 1'b0;
                        mmem_write_q <= 1'b0;
                        rdata_q      <= op_write_q ? '0 : bus.mmem_rdata;
                        rr_ptr       <= grant_q;
                        resp_q       <= grant_onehot;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Requests are ignored here; the winner drops its request now.
                    resp_q <= '0;
                    state  <= ST_IDLE;
                end
                default: begin
                    resp_q       <= '0;
                    mmem_read_q  <= 1'b0;
                    mmem_write_q <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mmem_read    = mmem_read_q;
    assign bus.mmem_write   = mmem_write_q;
    assign bus.mmem_address = addr_q;
    assign bus.mmem_wdata   = wdata_q;
    assign bus.cli_rdata    = rdata_q;
    assign bus.cli_resp     = resp_q;
    assign state_dbg        = state;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] cnt_q [N_CLIENTS];

    // Count grants on entry to ISSUE, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CLIENTS; i++) cnt_q[i] <= '0;
        end else if (state == ST_IDLE && grant_valid) begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                if (IDX_W'(i) == grant_idx && cnt_q[i] != 32'hFFFF_FFFF) begin
                    cnt_q[i] <= cnt_q[i] + 32'd1;
                end
            end
        end
    end

    // Pack the counters onto the flat output bus.
    always_comb begin
        perf_grant_cnt = '0;
        for (int i = 0; i < N_CLIENTS; i++) perf_grant_cnt[i*32 +: 32] = cnt_q[i];
    end
`else
    assign perf_grant_cnt = '0;
`endif

    // A client asking for read and write at once is a cache bug; the write is served.
    rw_conflict_a: assert property (@(posedge clk) disable iff (rst)
        (state != ST_IDLE) || ((bus.cli_read & bus.cli_write) == '0))
        else $warning("cacheline_arbiter_rr: read and write requested together, write served");

endmodule

// File: tb/tb_cacheline_arbiter_rr.sv
// Directed bench for cacheline_arbiter_rr: a vector table of single
// transactions on a 2-client instance plus hand sequences for arbitration
// order, reset mid-transfer and 4-client rotation.
module tb_cacheline_arbiter_rr;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cacheline_arbiter_rr_if #(.N_CLIENTS(2), .LINE_W(256), .ADDR_W(32)) bus2 ();
    cacheline_arbiter_rr_if #(.N_CLIENTS(4), .LINE_W(256), .ADDR_W(32)) bus4 ();

    logic [63:0]  perf2;
    logic [127:0] perf4;
    logic [1:0]   state2;
    logic [1:0]   state4;

    cacheline_arbiter_rr #(.N_CLIENTS(2), .LINE_W(256), .ADDR_W(32)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .perf_grant_cnt(perf2), .state_dbg(state2)
    );

    cacheline_arbiter_rr #(.N_CLIENTS(4), .LINE_W(256), .ADDR_W(32)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .perf_grant_cnt(perf4), .state_dbg(state4)
    );

`ifdef ARB_PERF_CNT_EN
    localparam logic [31:0] EXP_CNT = 32'd2;
`else
    localparam logic [31:0] EXP_CNT = 32'd0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           cli;
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wd;
        int           delay;
        logic [255:0] line;
        logic [1:0]   exp_resp;
        bit           exp_r;
        bit           exp_w;
        logic [255:0] exp_rdata;
        int           mode;   // 0 plain, 1 scramble client inputs in ISSUE, 2 withdraw request in ISSUE
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one 2-client transaction from an IDLE cycle whose requests are already driven.
    task automatic serve2(input logic [1:0] exp_resp, input int delay, input bit exp_r, input bit exp_w,
                          input logic [31:0] exp_addr, input logic [255:0] exp_wd,
                          input logic [255:0] line, input logic [255:0] exp_rdata, input int mode);
        int g;
        g = exp_resp[1] ? 1 : 0;
        for (int i = 1; i <= delay; i++) begin
            step();
            check("issue_state", state2, 2'd1);
            check("mmem_read", bus2.mmem_read, exp_r);
            check("mmem_write", bus2.mmem_write, exp_w);
            check("mmem_address", bus2.mmem_address, exp_addr);
            check("mmem_wdata", bus2.mmem_wdata, exp_wd);
            check("cli_resp_issue", bus2.cli_resp, 2'b00);
            if (i == 1 && mode == 1) begin
                bus2.cli_address[g*32 +: 32] = ~exp_addr;
                bus2.cli_wdata[g*256 +: 256] = ~exp_wd;
            end
            if (i == 1 && mode == 2) begin
                bus2.cli_read[g]  = 1'b0;
                bus2.cli_write[g] = 1'b0;
            end
            if (i == delay) begin
                bus2.mmem_resp  = 1'b1;
                bus2.mmem_rdata = line;
            end
        end
        step();
        bus2.mmem_resp  = 1'b0;
        bus2.mmem_rdata = '0;
        check("done_state", state2, 2'd2);
        check("strobes_after_resp", {bus2.mmem_read, bus2.mmem_write}, 2'b00);
        check("cli_resp", bus2.cli_resp, exp_resp);
        check("cli_rdata", bus2.cli_rdata, exp_rdata);
        bus2.cli_read[g]  = 1'b0;
        bus2.cli_write[g] = 1'b0;
        step();
        check("idle_state", state2, 2'd0);
        check("cli_resp_single_pulse", bus2.cli_resp, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] la5;
        logic [255:0] ldb;
        logic [3:0]   oh;
        int           exp_g;

        la5 = {32{8'hA5}};
        ldb = {8{32'hDEADBEEF}};

        vecs[0] = '{1, 1'b1, 1'b0, 32'h0000_1040, '0, 4, la5, 2'b10, 1'b1, 1'b0, la5, 1};
        vecs[1] = '{0, 1'b0, 1'b1, 32'h0000_2000, {16{16'h1234}}, 2, {32{8'h77}}, 2'b01, 1'b0, 1'b1, '0, 1};
        vecs[2] = '{1, 1'b1, 1'b1, 32'h0000_0080, ldb, 3, {32{8'h3C}}, 2'b10, 1'b0, 1'b1, '0, 1};
        vecs[3] = '{0, 1'b1, 1'b0, 32'hFFFF_FFC0, {8{32'h0BAD_F00D}}, 1, {32{8'h5A}}, 2'b01, 1'b1, 1'b0, {32{8'h5A}}, 0};
        vecs[4] = '{1, 1'b1, 1'b0, 32'h0000_0040, '0, 1, {256{1'b1}}, 2'b10, 1'b1, 1'b0, {256{1'b1}}, 0};
        vecs[5] = '{0, 1'b1, 1'b0, 32'h0000_3000, '0, 3, {4{64'h0123_4567_89AB_CDEF}}, 2'b01, 1'b1, 1'b0,
                    {4{64'h0123_4567_89AB_CDEF}}, 2};

        bus2.cli_read = '0; bus2.cli_write = '0; bus2.cli_address = '0; bus2.cli_wdata = '0;
        bus2.mmem_rdata = '0; bus2.mmem_resp = 1'b0;
        bus4.cli_read = '0; bus4.cli_write = '0; bus4.cli_address = '0; bus4.cli_wdata = '0;
        bus4.mmem_rdata = '0; bus4.mmem_resp = 1'b0;

        // Reset and reset values
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("rst_state", state2, 2'd0);
        check("rst_strobes", {bus2.mmem_read, bus2.mmem_write}, 2'b00);
        check("rst_address", bus2.mmem_address, 32'h0);
        check("rst_wdata", bus2.mmem_wdata, 256'h0);
        check("rst_cli_resp", bus2.cli_resp, 2'b00);
        check("rst_cli_rdata", bus2.cli_rdata, 256'h0);
        check("rst_perf", perf2, 64'h0);

        // Both clients from reset: 0 then 1, twice
        bus2.cli_address[0 +: 32]  = 32'h0000_A000;
        bus2.cli_address[32 +: 32] = 32'h0000_B000;
        for (int r = 0; r < 2; r++) begin
            bus2.cli_read = 2'b11;
            serve2(2'b01, 2, 1'b1, 1'b0, 32'h0000_A000, '0, {32{8'h11}}, {32{8'h11}}, 0);
            serve2(2'b10, 2, 1'b1, 1'b0, 32'h0000_B000, '0, {32{8'h22}}, {32{8'h22}}, 0);
        end

        // Single-transaction vector table
        for (int v = 0; v < 6; v++) begin
            bus2.cli_read[vecs[v].cli]             = vecs[v].rd;
            bus2.cli_write[vecs[v].cli]            = vecs[v].wr;
            bus2.cli_address[vecs[v].cli*32 +: 32] = vecs[v].addr;
            bus2.cli_wdata[vecs[v].cli*256 +: 256] = vecs[v].wd;
            serve2(vecs[v].exp_resp, vecs[v].delay, vecs[v].exp_r, vecs[v].exp_w, vecs[v].addr,
                   vecs[v].wd, vecs[v].line, vecs[v].exp_rdata, vecs[v].mode);
        end

        // Reset two cycles into an ISSUE abandons the transfer
        bus2.cli_address[0 +: 32] = 32'h0000_5000;
        bus2.cli_read[0] = 1'b1;
        step();
        step();
        check("pre_rst_read", bus2.mmem_read, 1'b1);
        rst = 1'b1;
        bus2.cli_read[0] = 1'b0;
        step();
        rst = 1'b0;
        check("post_rst_strobes", {bus2.mmem_read, bus2.mmem_write}, 2'b00);
        check("post_rst_state", state2, 2'd0);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_no_resp", bus2.cli_resp, 2'b00);
            step();
        end
        bus2.cli_address[32 +: 32] = 32'h0000_6000;
        bus2.cli_wdata[256 +: 256] = '0;
        bus2.cli_read[1] = 1'b1;
        serve2(2'b10, 2, 1'b1, 1'b0, 32'h0000_6000, '0, {32{8'h66}}, {32{8'h66}}, 0);

        // Four clients requesting continuously: strict rotation
        for (int c = 0; c < 4; c++) bus4.cli_address[c*32 +: 32] = 32'h100 * (c + 1);
        bus4.cli_read = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            exp_g = t % 4;
            step();
            check("rr4_issue_state", state4, 2'd1);
            check("rr4_mmem_read", bus4.mmem_read, 1'b1);
            check("rr4_address", bus4.mmem_address, 32'h100 * (exp_g + 1));
            bus4.mmem_resp  = 1'b1;
            bus4.mmem_rdata = {8{32'(t)}};
            step();
            bus4.mmem_resp  = 1'b0;
            oh = '0;
            oh[exp_g] = 1'b1;
            check("rr4_cli_resp", bus4.cli_resp, oh);
            check("rr4_cli_rdata", bus4.cli_rdata, {8{32'(t)}});
            step();
            check("rr4_resp_pulse", bus4.cli_resp, 4'b0000);
        end
        for (int c = 0; c < 4; c++) check("rr4_perf", perf4[c*32 +: 32], EXP_CNT);
        bus4.cli_read = '0;
        step();
        step();
        check("rr4_idle_after", state4, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
